// File: rtl/spi_master_ctrl_if.sv
// System handshake and SPI bus signals of spi_master_ctrl, grouped for port connection.
interface spi_master_ctrl_if;
    logic       start;
    logic [7:0] tx_data;
    logic       ready;
    logic       done;
    logic [7:0] rx_data;
    logic       SCLK;
    logic       CS;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, tx_data, MISO,
        output ready, done, rx_data, SCLK, CS, MOSI
    );

    modport slave (
        output start, tx_data, MISO,
        input  ready, done, rx_data, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one 8-bit full-duplex transfer per start/ready handshake.
// Bus outputs are registered from the current FSM state, so they trail the state by one clock.
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_ctrl_if.master bus
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t           state_r,    state_s;
    logic [7:0]       tx_shift_r, tx_shift_s;
    logic [7:0]       rx_shift_r, rx_shift_s;
    logic [2:0]       bit_cnt_r,  bit_cnt_s;
    logic [DIV_W-1:0] div_cnt_r,  div_cnt_s;
    logic [DIV_W-1:0] div_next_s;
    logic             phase_end_s;
    logic             accept_s;

    logic             ready_r,   ready_s;
    logic             done_r,    done_s;
    logic [7:0]       rx_data_r, rx_data_s;
    logic             sclk_r,    sclk_s;
    logic             cs_r,      cs_s;
    logic             mosi_r,    mosi_s;

    assign phase_end_s = (div_cnt_r == DIV_LAST);
    assign div_next_s  = phase_end_s ? DIV_ZERO : (div_cnt_r + DIV_ONE);
    assign accept_s    = (state_r == ST_IDLE) && bus.start && ready_r;

    // Next-state, shift datapath and next bus-output decode
    always_comb begin
        state_s    = state_r;
        tx_shift_s = tx_shift_r;
        rx_shift_s = rx_shift_r;
        bit_cnt_s  = bit_cnt_r;
        div_cnt_s  = div_cnt_r;
        ready_s    = ready_r;
        done_s     = 1'b0;
        rx_data_s  = rx_data_r;
        cs_s       = 1'b1;
        sclk_s     = 1'b0;
        mosi_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s    = ST_SETUP;
                    tx_shift_s = bus.tx_data;
                    rx_shift_s = 8'h00;
                    bit_cnt_s  = 3'd0;
                    div_cnt_s  = DIV_ZERO;
                    ready_s    = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                cs_s      = 1'b0;
                mosi_s    = tx_shift_r[7];
                div_cnt_s = div_next_s;
                if (phase_end_s) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_HIGH: begin
                cs_s      = 1'b0;
                sclk_s    = 1'b1;
                mosi_s    = tx_shift_r[7];
                div_cnt_s = div_next_s;
                // MISO is taken on the last high cycle, ahead of the slave's falling-edge shift
                if (phase_end_s) begin
                    rx_shift_s = {rx_shift_r[6:0], bus.MISO};
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s    = ST_LOW;
                        tx_shift_s = {tx_shift_r[6:0], 1'b0};
                        bit_cnt_s  = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                cs_s      = 1'b0;
                mosi_s    = tx_shift_r[7];
                div_cnt_s = div_next_s;
                if (phase_end_s) begin
                    state_s = ST_HIGH;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_HOLD: begin
                cs_s      = 1'b0;
                div_cnt_s = div_next_s;
                if (phase_end_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                done_s    = 1'b1;
                ready_s   = 1'b1;
                rx_data_s = rx_shift_r;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                ready_s = 1'b1;
            end
        endcase
    end

    // FSM state, datapath and registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tx_shift_r <= 8'h00;
            rx_shift_r <= 8'h00;
            bit_cnt_r  <= 3'd0;
            div_cnt_r  <= DIV_ZERO;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            rx_data_r  <= 8'h00;
            sclk_r     <= 1'b0;
            cs_r       <= 1'b1;
            mosi_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tx_shift_r <= tx_shift_s;
            rx_shift_r <= rx_shift_s;
            bit_cnt_r  <= bit_cnt_s;
            div_cnt_r  <= div_cnt_s;
            ready_r    <= ready_s;
            done_r     <= done_s;
            rx_data_r  <= rx_data_s;
            sclk_r     <= sclk_s;
            cs_r       <= cs_s;
            mosi_r     <= mosi_s;
        end
    end

    assign bus.ready   = ready_r;
    assign bus.done    = done_r;
    assign bus.rx_data = rx_data_r;
    assign bus.SCLK    = sclk_r;
    assign bus.CS      = cs_r;
    assign bus.MOSI    = mosi_r;

endmodule
